// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// clear-sequencer state encoding and the polarity of reset and write enables.
// Contents: DEF_DATA_W, DEF_ADDR_W, clr_state_t, RST_ACTIVE, WE_ACTIVE.
package regfile_mp_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Clear sequencer states, 2-bit encoding shared with the rest of the datapath.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_t;

  localparam logic RST_ACTIVE = 1'b1;
  localparam logic WE_ACTIVE  = 1'b1;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: hard-wired zero register, then write-port-1
// bypass, then write-port-0 bypass, then the stored entry.
// Ports: raddr/arr_data in (array already indexed by raddr), byp_en plus both
// write ports in, rdata out. Zero cycles of latency.
module regfile_rd_port import regfile_mp_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              byp_en,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata
);

  always_comb begin
    rdata = arr_data;
    if ((ZERO_REG != 0) && (raddr == '0)) begin
      rdata = '0;
    end else if (byp_en && (we1 == WE_ACTIVE) && (waddr1 == raddr)) begin
      // Port 1 has write priority, so its data must also win the bypass.
      rdata = wdata1;
    end else if (byp_en && (we0 == WE_ACTIVE) && (waddr0 == raddr)) begin
      rdata = wdata0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two prioritised
// write ports with write-to-read bypass, optional zero register, and a clear
// sequencer that zeroes one entry per cycle (IDLE -> SWEEP -> DONE).
// Ports: clk, rst (async, active-high), we/waddr/wdata x2, packed raddr/rdata,
// clr_req in, clr_busy/clr_done out. Writes are dropped while clr_busy is high.
module regfile_mp import regfile_mp_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  clr_state_t        state;
  clr_state_t        state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              cnt_last;
  logic              wr0_ok;
  logic              wr1_ok;

  assign cnt_last = (cnt == ADDR_W'(DEPTH - 1));

  // Writes only land while idle; address 0 is protected when it is hard-wired.
  assign wr0_ok = (we0 == WE_ACTIVE) && (state == ST_IDLE) &&
                  !((ZERO_REG != 0) && (waddr0 == '0));
  assign wr1_ok = (we1 == WE_ACTIVE) && (state == ST_IDLE) &&
                  !((ZERO_REG != 0) && (waddr1 == '0));

  // Clear FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ACTIVE) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Clear FSM: next state. clr_req is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (clr_req) state_nxt = ST_SWEEP;
      ST_SWEEP: if (cnt_last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Clear FSM: outputs decoded from registered state only.
  always_comb begin
    clr_busy = (state != ST_IDLE);
    clr_done = (state == ST_DONE);
  end

  // Sweep counter: restarts at 0 on every accepted request, holds on the last entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ACTIVE) begin
      cnt <= '0;
    end else if ((state == ST_IDLE) && clr_req) begin
      cnt <= '0;
    end else if ((state == ST_SWEEP) && !cnt_last) begin
      cnt <= cnt + ADDR_W'(1);
    end
  end

  // Array: sweep zeroing, otherwise the two write ports. Port 1 is assigned
  // last so it wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ACTIVE) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == ST_SWEEP) begin
      mem[cnt] <= '0;
    end else begin
      if (wr0_ok) mem[waddr0] <= wdata0;
      if (wr1_ok) mem[waddr1] <= wdata1;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[g*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .raddr   (ra),
      .arr_data(mem[ra]),
      .byp_en  (state == ST_IDLE),
      .we0     (we0),
      .waddr0  (waddr0),
      .wdata0  (wdata0),
      .we1     (we1),
      .waddr1  (waddr1),
      .wdata1  (wdata1),
      .rdata   (rdata[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three instances (default with zero register, default
// without it, and a 4-port 16-bit 8-entry one) checked every cycle against an
// array/phase model, plus directed literal checks.
module tb_regfile_mp;

  logic clk;
  logic rst;

  // Shared stimulus for instances a (ZERO_REG=1) and b (ZERO_REG=0)
  logic        we0, we1, clr_req;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic [9:0]  raddr;
  logic [63:0] rdata_a, rdata_b;
  logic        busy_a, done_a, busy_b, done_b;

  // Instance c: NUM_RD=4, DATA_W=16, ADDR_W=3, ZERO_REG=1
  logic        c_we0, c_we1, c_clr_req;
  logic [2:0]  c_waddr0, c_waddr1;
  logic [15:0] c_wdata0, c_wdata1;
  logic [11:0] c_raddr;
  logic [63:0] c_rdata;
  logic        c_busy, c_done;

  int n_chk = 0;
  int n_err = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .raddr(raddr), .rdata(rdata_a),
    .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a));

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .raddr(raddr), .rdata(rdata_b),
    .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b));

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1)) dut_c (
    .clk(clk), .rst(rst), .we0(c_we0), .waddr0(c_waddr0), .wdata0(c_wdata0),
    .we1(c_we1), .waddr1(c_waddr1), .wdata1(c_wdata1), .raddr(c_raddr), .rdata(c_rdata),
    .clr_req(c_clr_req), .clr_busy(c_busy), .clr_done(c_done));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  // ---------------- model ----------------
  // m[d][i]: stored contents. pos[d]: edges since the clear request was
  // accepted (0 = idle, 1..depth = sweeping, depth+1 = done cycle).
  logic [31:0] m [3][32];
  int pos [3];
  int depth [3] = '{32, 32, 8};
  int zr [3] = '{1, 0, 1};

  task automatic model_edge(input int d, input logic w0, input int a0, input logic [31:0] d0,
                            input logic w1, input int a1, input logic [31:0] d1, input logic req);
    if (pos[d] == 0) begin
      if (w0 && !(zr[d] != 0 && a0 == 0)) m[d][a0] = d0;
      if (w1 && !(zr[d] != 0 && a1 == 0)) m[d][a1] = d1;
      if (req) pos[d] = 1;
    end else if (pos[d] <= depth[d]) begin
      m[d][pos[d]-1] = 32'h0;
      pos[d] = pos[d] + 1;
    end else begin
      pos[d] = 0;
    end
  endtask

  function automatic logic [31:0] model_rd(input int d, input int a, input logic w0, input int a0,
                                           input logic [31:0] d0, input logic w1, input int a1,
                                           input logic [31:0] d1);
    if (zr[d] != 0 && a == 0) return 32'h0;
    if (pos[d] == 0 && w1 && a1 == a) return d1;
    if (pos[d] == 0 && w0 && a0 == a) return d0;
    return m[d][a];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        pos[d] = 0;
        for (int i = 0; i < 32; i++) m[d][i] = 32'h0;
      end
    end else begin
      model_edge(0, we0, int'(waddr0), wdata0, we1, int'(waddr1), wdata1, clr_req);
      model_edge(1, we0, int'(waddr0), wdata0, we1, int'(waddr1), wdata1, clr_req);
      model_edge(2, c_we0, int'(c_waddr0), {16'h0, c_wdata0}, c_we1, int'(c_waddr1),
                 {16'h0, c_wdata1}, c_clr_req);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, half a cycle away from the edge.
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      chk("rdata_a", rdata_a[p*32 +: 32],
          model_rd(0, int'(raddr[p*5 +: 5]), we0, int'(waddr0), wdata0, we1, int'(waddr1), wdata1));
      chk("rdata_b", rdata_b[p*32 +: 32],
          model_rd(1, int'(raddr[p*5 +: 5]), we0, int'(waddr0), wdata0, we1, int'(waddr1), wdata1));
    end
    for (int p = 0; p < 4; p++) begin
      chk("rdata_c", {16'h0, c_rdata[p*16 +: 16]},
          model_rd(2, int'(c_raddr[p*3 +: 3]), c_we0, int'(c_waddr0), {16'h0, c_wdata0},
                   c_we1, int'(c_waddr1), {16'h0, c_wdata1}));
    end
    chk("busy_a", {31'h0, busy_a}, {31'h0, pos[0] != 0});
    chk("done_a", {31'h0, done_a}, {31'h0, pos[0] == 33});
    chk("busy_b", {31'h0, busy_b}, {31'h0, pos[1] != 0});
    chk("done_b", {31'h0, done_b}, {31'h0, pos[1] == 33});
    chk("busy_c", {31'h0, c_busy}, {31'h0, pos[2] != 0});
    chk("done_c", {31'h0, c_done}, {31'h0, pos[2] == 9});
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int busy_n, done_n, done_at, n;

  initial begin
    rst = 1'b1;
    we0 = 0; we1 = 0; clr_req = 0; waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0; raddr = 0;
    c_we0 = 0; c_we1 = 0; c_clr_req = 0; c_waddr0 = 0; c_waddr1 = 0;
    c_wdata0 = 0; c_wdata1 = 0; c_raddr = 0;
    repeat (3) tick;
    rst = 1'b0;
    #1;
    chk("reset_rdata", rdata_a[31:0], 32'h0);
    chk("reset_busy", {31'h0, busy_a}, 32'h0);

    // Write r5 via port 0: bypass now, stored after the edge on both ports.
    raddr = {5'd5, 5'd5};
    we0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    #1 chk("r5_bypass", rdata_a[31:0], 32'hDEADBEEF);
    tick;
    we0 = 0;
    #1;
    chk("r5_port0", rdata_a[31:0], 32'hDEADBEEF);
    chk("r5_port1", rdata_a[63:32], 32'hDEADBEEF);
    chk("r5_b", rdata_b[31:0], 32'hDEADBEEF);

    // Asynchronous reset in the middle of a cycle.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rd0", rdata_a[31:0], 32'h0);
    chk("async_rst_rd1", rdata_a[63:32], 32'h0);
    chk("async_rst_busy", {31'h0, busy_a}, 32'h0);
    tick;
    rst = 1'b0;

    // Both ports write r7: port 1 wins, both in bypass and in storage.
    raddr = {5'd7, 5'd7};
    we0 = 1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1; waddr1 = 5'd7; wdata1 = 32'h22;
    #1 chk("r7_bypass_prio", rdata_a[31:0], 32'h22);
    tick;
    we0 = 0; we1 = 0;
    #1 chk("r7_stored", rdata_a[31:0], 32'h22);

    // Zero register: a keeps reading 0, b stores the value.
    raddr = {5'd0, 5'd0};
    #1 chk("r0_a_before", rdata_a[31:0], 32'h0);
    we0 = 1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
    we1 = 1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    #1 chk("r0_a_bypass", rdata_a[31:0], 32'h0);
    tick;
    we0 = 0; we1 = 0;
    #1;
    chk("r0_a_after", rdata_a[31:0], 32'h0);
    chk("r0_b_after", rdata_b[31:0], 32'hFFFFFFFF);

    // Fill r1..r31 with their index, then run a full clear.
    for (int i = 1; i < 32; i++) begin
      we0 = 1; waddr0 = 5'(i); wdata0 = 32'(i);
      tick;
    end
    we0 = 0;
    raddr = {5'd3, 5'd31};
    #1 chk("fill_r31", rdata_a[31:0], 32'd31);
    clr_req = 1;
    tick;
    clr_req = 0;
    busy_n = 0; done_n = 0; done_at = -1;
    while (busy_a && busy_n < 100) begin
      if (done_a) begin
        done_n++;
        done_at = busy_n;
      end
      // r3 is already cleared by now; this write must be dropped.
      we0 = (busy_n == 5); waddr0 = 5'd3; wdata0 = 32'h33;
      busy_n++;
      tick;
    end
    we0 = 0;
    chk("clr_busy_cycles", 32'(busy_n), 32'd33);
    chk("clr_done_pulses", 32'(done_n), 32'd1);
    chk("clr_done_pos", 32'(done_at), 32'd32);
    #1 chk("r3_dropped", rdata_a[63:32], 32'h0);
    for (int i = 0; i < 32; i += 2) begin
      raddr = {5'(i + 1), 5'(i)};
      #1;
      chk("cleared_lo", rdata_b[31:0], 32'h0);
      chk("cleared_hi", rdata_b[63:32], 32'h0);
    end

    // Reset while the sweep counter is at 10.
    we0 = 1; waddr0 = 5'd20; wdata0 = 32'h2020;
    tick;
    we0 = 0;
    raddr = {5'd20, 5'd20};
    clr_req = 1;
    tick;
    clr_req = 0;
    repeat (10) tick;
    chk("mid_busy_before", {31'h0, busy_a}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'h0, busy_a}, 32'h0);
    chk("mid_rst_done", {31'h0, done_a}, 32'h0);
    chk("mid_rst_r20", rdata_a[31:0], 32'h0);
    tick;
    rst = 1'b0;
    raddr = {5'd12, 5'd12};
    we1 = 1; waddr1 = 5'd12; wdata1 = 32'hABC;
    tick;
    we1 = 0;
    #1 chk("post_rst_r12", rdata_a[31:0], 32'hABC);

    // A new clear restarts at entry 0.
    we0 = 1; waddr0 = 5'd0; wdata0 = 32'h5;
    we1 = 1; waddr1 = 5'd1; wdata1 = 32'h1;
    tick;
    we0 = 0; we1 = 0;
    raddr = {5'd1, 5'd0};
    #1 chk("b_r0_preclr", rdata_b[31:0], 32'h5);
    clr_req = 1;
    tick;
    clr_req = 0;
    tick;
    chk("restart_r0_cleared", rdata_b[31:0], 32'h0);
    chk("restart_r1_kept", rdata_b[63:32], 32'h1);
    tick;
    chk("restart_r1_cleared", rdata_b[63:32], 32'h0);
    n = 0;
    while (busy_a && n < 100) begin
      n++;
      tick;
    end
    chk("restart_finished", {31'h0, busy_a}, 32'h0);

    // Instance c: four ports, 16-bit data, 8 entries.
    for (int i = 1; i < 8; i++) begin
      c_we0 = 1; c_waddr0 = 3'(i); c_wdata0 = 16'h1000 + 16'(i);
      c_we1 = (i % 2 == 1); c_waddr1 = 3'(i); c_wdata1 = 16'h2000 + 16'(i);
      tick;
    end
    c_we0 = 0; c_we1 = 0;
    c_raddr = {3'd6, 3'd5, 3'd2, 3'd1};
    #1;
    chk("c_port0_r1", {16'h0, c_rdata[15:0]}, 32'h2001);
    chk("c_port1_r2", {16'h0, c_rdata[31:16]}, 32'h1002);
    chk("c_port2_r5", {16'h0, c_rdata[47:32]}, 32'h2005);
    chk("c_port3_r6", {16'h0, c_rdata[63:48]}, 32'h1006);
    c_raddr = {3'd0, 3'd7, 3'd4, 3'd3};
    #1;
    chk("c_port0_r3", {16'h0, c_rdata[15:0]}, 32'h2003);
    chk("c_port1_r4", {16'h0, c_rdata[31:16]}, 32'h1004);
    chk("c_port2_r7", {16'h0, c_rdata[47:32]}, 32'h2007);
    chk("c_port3_r0", {16'h0, c_rdata[63:48]}, 32'h0);
    c_clr_req = 1;
    tick;
    c_clr_req = 0;
    busy_n = 0; done_n = 0;
    while (c_busy && busy_n < 100) begin
      if (c_done) done_n++;
      busy_n++;
      tick;
    end
    chk("c_busy_cycles", 32'(busy_n), 32'd9);
    chk("c_done_pulses", 32'(done_n), 32'd1);
    chk("c_cleared_r3", {16'h0, c_rdata[15:0]}, 32'h0);
    chk("c_cleared_r7", {16'h0, c_rdata[47:32]}, 32'h0);
    repeat (2) tick;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the CPU datapath. It provides NUM_RD combinational read ports, two prioritised write ports with write-to-read bypass, and an optional hard-wired zero register. A handshaked clear sequencer zeroes the array one entry per cycle without asserting reset. It replaces the fixed 2-read/1-write register file in the decode stage and supports dual-issue writeback.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, entry 0 always reads 0 and ignores writes

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (higher priority)
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- raddr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  packed read data; port i uses bits [i*DATA_W +: DATA_W]
- clr_req  in  1  request a full-array clear (level, sampled in IDLE)
- clr_busy  out  1  clear in progress; writes are dropped while high
- clr_done  out  1  one-cycle pulse when the clear completes

## Operation
- Reset: all entries are 0, FSM is IDLE, the sweep counter is 0, and clr_busy = clr_done = 0. This takes effect immediately and is independent of clk.
- Write, when not busy: at the posedge, entry[waddrN] <= wdataN for each port N with weN = 1.
  - Both ports writing the same address: port 1 wins.
  - With ZERO_REG = 1, writes to address 0 are discarded.
- Read, combinational for each port i. Priority, highest first:
  - ZERO_REG = 1 and raddr_i == 0 → 0.
  - Not busy, we1 = 1 and waddr1 == raddr_i → wdata1.
  - Not busy, we0 = 1 and waddr0 == raddr_i → wdata0.
  - Otherwise → entry[raddr_i].
- Bypass is disabled while clr_busy = 1.
- Clear FSM states are IDLE, SWEEP and DONE.
  - IDLE: if clr_req = 1 at the posedge, go to SWEEP and set cnt = 0.
  - SWEEP: each posedge writes entry[cnt] <= 0. If cnt == DEPTH-1, go to DONE; otherwise increment cnt.
  - DONE: go to IDLE at the next posedge.
  - clr_req is ignored in SWEEP and DONE. A request held high through DONE starts a new clear on the first edge back in IDLE.
- Outputs: clr_busy = (state != IDLE) and clr_done = (state == DONE), both decoded from registered state.
- Writes presented during SWEEP or DONE are dropped. The producer must stall on clr_busy.
- Reads during SWEEP return the current array contents, which is a mix of cleared and uncleared entries.

## Timing
- Write latency: data is in the array after 1 edge. Same-cycle visibility on rdata comes through the bypass path.
- Read latency: 0 cycles (combinational from raddr, array and write ports).
- Clear latency, with clr_req sampled at edge E0:
  - clr_busy rises after E0 and stays high for DEPTH+1 cycles.
  - Entries are zeroed at edges E1..E_DEPTH.
  - clr_done is high for the cycle between E_DEPTH and E_DEPTH+1.
- Throughput: back-to-back clears need at least 1 IDLE cycle between them, so the period is DEPTH+2 cycles.
- rst asserted mid-sweep: the array and FSM reset immediately, and no clr_done pulse is generated.
- Dual write with waddr0 == waddr1 == 0 and ZERO_REG = 1: no state change.

## Structure
- Shared package/header (with the existing defines): default DATA_W/ADDR_W, FSM state encodings (2-bit: IDLE=0, SWEEP=1, DONE=2), reset/enable polarity constants.
- Sub-module regfile_rd_port is natural: one read mux with zero-reg and two-port bypass logic, instantiated NUM_RD times in a generate loop.
- Top level holds the array, write logic, sweep counter (ADDR_W bits) and FSM.

## Test plan
- Reset and read:
  - Assert rst mid-cycle → all rdata = 0 immediately, clr_busy = 0.
  - Write 0xDEADBEEF to r5 via port 0, then read r5 on all ports next cycle → 0xDEADBEEF.
- Bypass and priority:
  - Same cycle: we0 r7 = 0x11, we1 r7 = 0x22, raddr[0] = 7 → rdata[0] = 0x22 combinationally.
  - After the edge, r7 = 0x22.
- Zero register:
  - With ZERO_REG = 1, write 0xFFFFFFFF to r0 via both ports while reading r0 → rdata = 0 before and after.
  - With ZERO_REG = 0, the same sequence → 0xFFFFFFFF after the edge.
- Clear sequence:
  - Fill r1..r31 with index values, pulse clr_req for 1 cycle → clr_busy high 33 cycles, clr_done one pulse 33 cycles after the sampling edge, all entries 0.
  - A write to r3 during SWEEP is dropped: r3 reads 0 afterwards.
- Reset mid-clear:
  - Start a clear, assert rst at sweep cnt = 10 → busy drops immediately, no clr_done.
  - Entries written afterwards read back correctly, and a new clr_req starts at cnt = 0.
- Parameter sweep:
  - Rerun the scenarios above with NUM_RD = 4, DATA_W = 16, ADDR_W = 3 → four independent ports read distinct addresses correctly.
  - Clear takes 9 busy cycles.
